// File: rtl/key_digit_mux_pkg.sv
// Shared types and constants for the keypad digit display path:
// scheduler states, keypad legend and active-low seven-segment glyphs.
package key_disp_pkg;

    typedef enum logic [1:0] {
        SHOW_R  = 2'd0,
        BLANK_R = 2'd1,
        SHOW_L  = 2'd2,
        BLANK_L = 2'd3
    } mux_state_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] idx;
    } onecold_t;

    // Indexed [row][col]; each 16-bit row holds col3..col0 from MSB to LSB.
    localparam logic [3:0][3:0][3:0] KEYMAP = 64'hDF0E_C987_B654_A321;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slot.
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic onecold_t onecold_decode(input logic [3:0] n);
        onecold_t res;
        res = '{ok: 1'b1, idx: 2'd0};
        case (n)
            4'b1110: res.idx = 2'd0;
            4'b1101: res.idx = 2'd1;
            4'b1011: res.idx = 2'd2;
            4'b0111: res.idx = 2'd3;
            default: res.ok  = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/key_digit_mux_if.sv
// Key event input and display output bundle of key_digit_mux.
interface key_digit_mux_if;
    logic       key_valid;
    logic [7:0] keypress;
    logic [6:0] seg;
    logic [1:0] an;
    logic [7:0] digits;
    logic       key_err;

    modport master (
        output key_valid, keypress,
        input  seg, an, digits, key_err
    );

    modport slave (
        input  key_valid, keypress,
        output seg, an, digits, key_err
    );
endinterface

// File: rtl/key_digit_mux_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg
    import key_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_GLYPH[hex_i];

endmodule

// File: rtl/key_digit_mux.sv
// Keypad code decode into a two-digit shift register, time-multiplexed
// onto one active-low seven-segment driver with a blanking gap.
module key_digit_mux
    import key_disp_pkg::*;
#(
    parameter int DWELL = 24000,
    parameter int BLANK = 480,
    parameter int CW    = 16
) (
    input logic            int_osc,
    input logic            reset,
    key_digit_mux_if.slave bus
);

    mux_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    left_q, left_d, right_q, right_d;
    logic          err_q, err_d;
    logic [1:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    onecold_t   col_dec, row_dec;
    logic       key_ok;
    logic [3:0] key_hex;
    logic       in_show, cnt_last;
    logic [3:0] sel_digit;
    logic [6:0] sel_seg;

    assign col_dec = onecold_decode(bus.keypress[7:4]);
    assign row_dec = onecold_decode(bus.keypress[3:0]);
    assign key_ok  = col_dec.ok & row_dec.ok;
    assign key_hex = KEYMAP[row_dec.idx][col_dec.idx];

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        err_d   = bus.key_valid & ~key_ok;
        if (bus.key_valid && key_ok) begin
            left_d  = right_q;
            right_d = key_hex;
        end
    end

    assign in_show  = (state_q == SHOW_R) || (state_q == SHOW_L);
    assign cnt_last = in_show ? (cnt_q == CW'(DWELL - 1))
                              : (cnt_q == CW'(BLANK - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_last) begin
            cnt_d = '0;
            case (state_q)
                SHOW_R:  state_d = BLANK_R;
                BLANK_R: state_d = SHOW_L;
                SHOW_L:  state_d = BLANK_L;
                default: state_d = SHOW_R;
            endcase
        end
    end

    // Display outputs follow the next state so they switch on the same edge
    // as the scheduler; the glyph uses the digit value held before this edge.
    always_comb begin
        an_d      = 2'b11;
        seg_d     = SEG_BLANK;
        sel_digit = right_q;
        case (state_d)
            SHOW_R: begin
                an_d  = 2'b10;
                seg_d = sel_seg;
            end
            SHOW_L: begin
                an_d      = 2'b01;
                sel_digit = left_q;
                seg_d     = sel_seg;
            end
            default: begin
                an_d  = 2'b11;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .hex_i (sel_digit),
        .seg_o (sel_seg)
    );

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state_q <= BLANK_L;
            cnt_q   <= '0;
            left_q  <= 4'h0;
            right_q <= 4'h0;
            err_q   <= 1'b0;
            an_q    <= 2'b11;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            err_q   <= err_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.digits  = {left_q, right_q};
    assign bus.key_err = err_q;

endmodule

// File: tb/tb_key_digit_mux.sv
// Randomised and directed bench for key_digit_mux against a behavioural model.
module tb_key_digit_mux;

    localparam int D = 4;
    localparam int B = 2;
    localparam int P = 2 * (D + B);

    logic int_osc = 1'b0;
    logic reset   = 1'b0;

    key_digit_mux_if bus();

    key_digit_mux #(.DWELL(D), .BLANK(B), .CW(16)) dut (
        .int_osc (int_osc),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 int_osc = ~int_osc;

    int ntests = 0;
    int nfail  = 0;
    bit chk_en = 1'b0;

    // Keypad legend by [row][col] and standard hex glyphs, active-low {g..a}.
    int KEY [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
    logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic bit mvalid(input logic [7:0] kp);
        int zc = 0;
        int zr = 0;
        for (int i = 0; i < 4; i++) begin
            if (!kp[4+i]) zc++;
            if (!kp[i])   zr++;
        end
        return (zc == 1) && (zr == 1);
    endfunction

    function automatic logic [3:0] mhex(input logic [7:0] kp);
        int c = 0;
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (!kp[4+i]) c = i;
            if (!kp[i])   r = i;
        end
        return 4'(KEY[r][c]);
    endfunction

    function automatic logic [7:0] mkcode(input int r, input int c);
        logic [3:0] one = 4'b0001;
        return {~(one << c), ~(one << r)};
    endfunction

    // Model: k counts edges since reset release; digits shift on valid strobes.
    int         k   = 0;
    logic [3:0] m_l = 4'h0, m_r = 4'h0, p_l = 4'h0, p_r = 4'h0;
    logic       m_err = 1'b0;

    always @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            k <= 0; m_l <= 4'h0; m_r <= 4'h0; p_l <= 4'h0; p_r <= 4'h0; m_err <= 1'b0;
        end else begin
            k     <= k + 1;
            p_l   <= m_l;
            p_r   <= m_r;
            m_err <= bus.key_valid && !mvalid(bus.keypress);
            if (bus.key_valid && mvalid(bus.keypress)) begin
                m_l <= m_r;
                m_r <= mhex(bus.keypress);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Rotation position q: SHOW_R [0,D), BLANK_R [D,D+B), SHOW_L [D+B,2D+B), BLANK_L after.
    always @(negedge int_osc) begin
        if (chk_en) begin
            logic [1:0] e_an;
            logic [6:0] e_seg;
            int q;
            e_an  = 2'b11;
            e_seg = 7'h7F;
            if (reset && k > 0) begin
                q = (k + 2 * D + B) % P;
                if (q < D) begin
                    e_an = 2'b10; e_seg = GLY[p_r];
                end else if (q >= D + B && q < 2 * D + B) begin
                    e_an = 2'b01; e_seg = GLY[p_l];
                end
            end
            check("an",      32'(bus.an),      32'(e_an));
            check("seg",     32'(bus.seg),     32'(e_seg));
            check("digits",  32'(bus.digits),  32'({m_l, m_r}));
            check("key_err", 32'(bus.key_err), 32'(m_err));
        end
    end

    task automatic wait_an(input logic [1:0] v, input string nm);
        int n = 0;
        while (bus.an !== v && n < 100) begin
            @(negedge int_osc);
            n++;
        end
        check(nm, 32'(bus.an === v), 32'd1);
    endtask

    task automatic strobe(input logic [7:0] kp);
        @(negedge int_osc);
        bus.key_valid = 1'b1;
        bus.keypress  = kp;
        @(negedge int_osc);
        bus.key_valid = 1'b0;
        bus.keypress  = 8'hFF;
    endtask

    initial begin
        int n;
        int runs [$];
        logic [1:0] rvals [$];
        logic [1:0] cur;
        int len;

        bus.key_valid = 1'b0;
        bus.keypress  = 8'hFF;
        repeat (2) @(negedge int_osc);
        chk_en = 1'b1;
        repeat (3) @(negedge int_osc);
        check("hold_an",     32'(bus.an),     32'h3);
        check("hold_seg",    32'(bus.seg),    32'h7F);
        check("hold_digits", 32'(bus.digits), 32'h00);

        reset = 1'b1;
        n = 0;
        do begin
            @(negedge int_osc);
            n++;
        end while (bus.an === 2'b11 && n < 50);
        check("first_show_edges", 32'(n), 32'(B));
        check("first_show_an",    32'(bus.an),  32'b10);
        check("first_show_seg",   32'(bus.seg), 32'b1000000);

        strobe(8'b1101_1110);
        strobe(8'b1110_1011);
        check("digits_27", 32'(bus.digits), 32'h27);
        wait_an(2'b11, "wait_blank_a");
        wait_an(2'b10, "wait_show_r");
        @(negedge int_osc);
        check("seg_show_r_7", 32'(bus.seg), 32'b1111000);
        wait_an(2'b01, "wait_show_l");
        @(negedge int_osc);
        check("seg_show_l_2", 32'(bus.seg), 32'b0100100);

        strobe(8'b1100_1110);
        check("err_a_pulse",  32'(bus.key_err), 32'd1);
        check("err_a_digits", 32'(bus.digits),  32'h27);
        @(negedge int_osc);
        check("err_a_clear",  32'(bus.key_err), 32'd0);
        strobe(8'b1110_1111);
        check("err_b_pulse",  32'(bus.key_err), 32'd1);
        check("err_b_digits", 32'(bus.digits),  32'h27);
        @(negedge int_osc);
        check("err_b_clear",  32'(bus.key_err), 32'd0);

        // Three full rotations starting at the first SHOW_R cycle.
        wait_an(2'b11, "wait_blank_b");
        wait_an(2'b10, "wait_rot_start");
        cur = bus.an;
        len = 1;
        for (int i = 1; i < 3 * P; i++) begin
            @(negedge int_osc);
            check("an_not_00", 32'(bus.an != 2'b00), 32'd1);
            if (bus.an === cur) len++;
            else begin
                runs.push_back(len); rvals.push_back(cur);
                cur = bus.an; len = 1;
            end
        end
        runs.push_back(len); rvals.push_back(cur);
        check("run_count", 32'(runs.size()), 32'd12);
        for (int i = 0; i < runs.size() && i < 12; i++) begin
            check("run_len", 32'(runs[i]), (i % 2 == 0) ? 32'(D) : 32'(B));
            check("run_an",  32'(rvals[i]), (i % 4 == 0) ? 32'b10 : (i % 4 == 2) ? 32'b01 : 32'b11);
        end

        @(negedge int_osc);
        bus.key_valid = 1'b1;
        bus.keypress  = 8'b0111_0111;
        @(negedge int_osc);
        bus.keypress  = 8'b1101_0111;
        check("b2b_d_digits", 32'(bus.digits[3:0]), 32'hD);
        check("b2b_d_err",    32'(bus.key_err),     32'd0);
        @(negedge int_osc);
        bus.key_valid = 1'b0;
        bus.keypress  = 8'hFF;
        check("b2b_digits", 32'(bus.digits),  32'hD0);
        check("b2b_err",    32'(bus.key_err), 32'd0);

        for (int i = 0; i < 400; i++) begin
            @(negedge int_osc);
            bus.key_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 7)
                bus.keypress = mkcode(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                bus.keypress = 8'($urandom);
        end
        @(negedge int_osc);
        bus.key_valid = 1'b0;

        strobe(8'b1101_1110);
        wait_an(2'b01, "wait_show_l_rst");
        @(negedge int_osc);
        #2 reset = 1'b0;
        #1;
        check("rst_an",     32'(bus.an),      32'h3);
        check("rst_seg",    32'(bus.seg),     32'h7F);
        check("rst_digits", 32'(bus.digits),  32'h00);
        check("rst_err",    32'(bus.key_err), 32'd0);
        repeat (4) @(negedge int_osc);
        reset = 1'b1;
        repeat (2 * P) @(negedge int_osc);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/key_digit_mux.md
# key_digit_mux

Consumes debounced key events from the keypad scanner, decodes each `{cols, rows}` code to a hex value, and shifts it into a two-digit register. The new key becomes the right digit and the old right digit moves left. A four-state scheduler time-shares one active-low seven-segment driver between the two digits, with a blanking gap to suppress ghosting. The block sits between the scanner FSM and the board's dual-digit display.

## Interface
- `DWELL`, default 24000: cycles each digit is lit (0.5 ms at 48 MHz); legal range ≥1.
- `BLANK`, default 480: cycles both digits are dark between digits; legal range ≥1.
- `CW`, default 16: counter width; must satisfy 2^CW > max(DWELL, BLANK).
- `int_osc`  in  1  system clock, 48 MHz.
- `reset`  in  1  reset, asynchronous, active-low.
- `key_valid`  in  1  single-cycle strobe from the scanner; a new key is held in `keypress`.
- `keypress`  in  8  `{cols[3:0], rows[3:0]}`, both active-low, expected one-cold.
- `seg`  out  7  active-low segments `{g,f,e,d,c,b,a}`.
- `an`  out  2  active-low digit enables; `an[0]` is the right digit, `an[1]` is the left digit.
- `digits`  out  8  `{left, right}` hex values, for debug and LEDs.
- `key_err`  out  1  one-cycle pulse when a strobed code is invalid.

## Operation
- Decode: `c` is the index of the single 0 in `cols`; `r` is the index of the single 0 in `rows`.
  - Row 0 reads `1 2 3 A` for c = 0..3.
  - Row 1 reads `4 5 6 B`.
  - Row 2 reads `7 8 9 C`.
  - Row 3 reads `E 0 F D`.
- Invalid code: either nibble has zero 0s or more than one 0. The digits are unchanged and `key_err` is raised.
- On a valid strobe: `right <= code`, `left <= old right`. Every strobe shifts, including a repeated identical key.
- Scheduler FSM with states SHOW_R, BLANK_R, SHOW_L, BLANK_L, cycling in that order:
  - SHOW_R: `an=2'b10`, `seg=enc(right)`.
  - SHOW_L: `an=2'b01`, `seg=enc(left)`.
  - BLANK_*: `an=2'b11`, `seg=7'h7F`.
- Phase counter:
  - Counts 0..DWELL-1 in SHOW states and 0..BLANK-1 in BLANK states.
  - On reaching the terminal count it clears to 0 and the FSM advances.
- Encoding examples: 0→`1000000`, 1→`1111001`, 8→`0000000`, A→`0001000`, F→`0001110`. All other values use the standard hex glyphs (b and d lowercase).
- `key_valid` is ignored unless it is high at a clock edge. The scheduler never stalls for key events.

## Timing
- Reset values:
  - Digits: `left=0`, `right=0`.
  - `key_err=0`, `an=2'b11`, `seg=7'h7F`.
  - FSM in BLANK_L, counter 0.
- After reset release, the first SHOW_R begins BLANK cycles later.
- `digits` updates at the edge that samples `key_valid=1` (0-cycle register latency; visible in the following cycle).
- `key_err` is high for exactly the cycle after the edge that samples an invalid strobe.
- `seg` and `an` are registered from next-state and the digit registers. A key landing while its digit is shown appears on `seg` one cycle after `digits` changes.
- Back-to-back strobes in consecutive cycles each shift; no events are dropped.
- Full rotation period is 2·(DWELL+BLANK) cycles. With defaults: 48960 cycles, ≈980 Hz per digit.
- Asynchronous reset mid-rotation forces the reset values immediately, with no partial shift.

## Structure
- Shared package `key_disp_pkg` holds:
  - enum `mux_state_t` (2 bits),
  - the keypad lookup constant (4×4 of 4-bit),
  - the segment constants for blank and the 16 glyphs.
- One sub-module, `hex_to_seg`: combinational, 4-bit in → 7-bit active-low out. Instantiated once on the selected digit.
- Key decode, shift register, counter and FSM live in the top.

## Test plan
- Reset hold then release → `an=11`, `seg=7F`, `digits=00` during the reset hold and for BLANK cycles after release; then `an=10`, `seg=1000000`.
- Strobe `keypress=8'b1101_1110` (c=1, r=0 → 2), then `8'b1110_1011` (c=0, r=2 → 7) → `digits=8'h27`.
  - During SHOW_R, `seg=1111000`.
  - During SHOW_L, `seg=0100100`.
- Strobe `keypress=8'b1100_1110` → `key_err` pulses one cycle, `digits` unchanged.
  - Likewise for `8'b1110_1111`.
- With DWELL=4, BLANK=2, count cycles of each `an` value over 3 rotations → exactly 4/2/4/2 repeating, never `an=00`.
- Two strobes on consecutive edges (D then 0) → `digits=8'hD0`, no `key_err`.
- Assert reset mid-SHOW_L → outputs immediately return to their reset values (`an=11`, `seg=7F`, `digits=00`) and stay there while reset is held.
